// File: rtl/condition_evaluator_if.sv
// Bus between the condition evaluator and its neighbours.
// The master drives the ALU flags, the condition field and the pipeline controls.
// The slave returns the status register and the registered condition result.
//   flags_in   : ALU flags {N,Z,C,V}
//   flags_we   : load flags_in into the status register
//   cond       : instruction condition field
//   eval_req   : request an evaluation of cond this cycle
//   stall      : pipeline hold
//   flush      : discard any result being produced
//   flags_out  : current status register {N,Z,C,V}
//   cond_true  : registered evaluation result
//   cond_valid : cond_true holds the result for the request accepted last cycle
interface condition_evaluator_if;
  logic [3:0] flags_in;
  logic       flags_we;
  logic [3:0] cond;
  logic       eval_req;
  logic       stall;
  logic       flush;
  logic [3:0] flags_out;
  logic       cond_true;
  logic       cond_valid;

  modport master (
    output flags_in, flags_we, cond, eval_req, stall, flush,
    input  flags_out, cond_true, cond_valid
  );

  modport slave (
    input  flags_in, flags_we, cond, eval_req, stall, flush,
    output flags_out, cond_true, cond_valid
  );
endinterface

// File: rtl/condition_evaluator.sv
// Condition evaluator. It owns the status register {N,Z,C,V} and evaluates the 4-bit instruction
// condition field against it. It delivers a registered cond_true/cond_valid pair to the
// control unit.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of condition_evaluator_if (flags, condition, pipeline controls, result)
// Parameters:
//   BYPASS      : 1 = evaluate on flags_in when flags_we is high in the same cycle
//   RESET_FLAGS : status register value after reset
module condition_evaluator #(
  parameter bit         BYPASS      = 1'b1,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                  clk,
  input  logic                  reset,
  condition_evaluator_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StValid} state_e;

  state_e     state_q, state_d;
  logic       cond_true_q, cond_true_d;
  logic [3:0] sr_q, sr_d;
  logic [3:0] eff_flags;
  logic       eval_result;

  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic res;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'h0:    res = z;
      4'h1:    res = ~z;
      4'h2:    res = cy;
      4'h3:    res = ~cy;
      4'h4:    res = n;
      4'h5:    res = ~n;
      4'h6:    res = v;
      4'h7:    res = ~v;
      4'h8:    res = cy & ~z;
      4'h9:    res = ~cy | z;
      4'hA:    res = (n == v);
      4'hB:    res = (n != v);
      4'hC:    res = ~z & (n == v);
      4'hD:    res = z | (n != v);
      4'hE:    res = 1'b1;
      default: res = 1'b0;  // NV: reserved, never true
    endcase
    return res;
  endfunction

  // Same-cycle flag writes are forwarded into the evaluation only when BYPASS is set.
  assign eff_flags   = (BYPASS && bus.flags_we) ? bus.flags_in : sr_q;
  assign eval_result = eval_cond(bus.cond, eff_flags);

  always_comb begin
    state_d     = state_q;
    cond_true_d = cond_true_q;
    sr_d        = sr_q;
    if (bus.flush) begin
      // Flush overrides stall, so a flag write in the same cycle still lands.
      state_d     = StIdle;
      cond_true_d = 1'b0;
      if (bus.flags_we) sr_d = bus.flags_in;
    end else if (bus.stall) begin
      // Hold everything; flags_we and eval_req are ignored.
    end else if (bus.eval_req) begin
      state_d     = StValid;
      cond_true_d = eval_result;
      if (bus.flags_we) sr_d = bus.flags_in;
    end else begin
      state_d     = StIdle;
      cond_true_d = 1'b0;
      if (bus.flags_we) sr_d = bus.flags_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cond_true_q <= 1'b0;
      sr_q        <= RESET_FLAGS;
    end else begin
      state_q     <= state_d;
      cond_true_q <= cond_true_d;
      sr_q        <= sr_d;
    end
  end

  assign bus.flags_out  = sr_q;
  assign bus.cond_true  = cond_true_q;
  assign bus.cond_valid = (state_q == StValid);

endmodule

// File: tb/tb_condition_evaluator.sv
// Scoreboard bench for condition_evaluator. Accepted requests push their expected result.
// A monitor on the falling edge pops it whenever a fresh result is presented.
// Direct checks of other outputs are queued to the same monitor.
module tb_condition_evaluator;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  condition_evaluator_if bus ();

  condition_evaluator #(
    .BYPASS      (1'b1),
    .RESET_FLAGS (4'b0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } direct_t;

  typedef struct {
    string name;
    logic  exp;
  } result_t;

  result_t exp_q[$];
  direct_t dir_q[$];
  int      checks = 0;
  int      errors = 0;
  logic    stall_seen = 1'b0;

  // Hand-computed truth masks: bit index is {N,Z,C,V} of the flags, one row per condition.
  logic [15:0] truth [16] = '{
    16'hF0F0, 16'h0F0F, 16'hCCCC, 16'h3333,  // EQ NE CS CC
    16'hFF00, 16'h00FF, 16'hAAAA, 16'h5555,  // MI PL VS VC
    16'h0C0C, 16'hF3F3, 16'hAA55, 16'h55AA,  // HI LS GE LT
    16'h0A05, 16'hF5FA, 16'hFFFF, 16'h0000   // GT LE AL NV
  };

  // A result presented after a stalled edge is the held one, not a new result.
  always @(posedge clk) stall_seen <= bus.stall;

  always @(negedge clk) begin
    direct_t d;
    result_t r;
    while (dir_q.size() > 0) begin
      d = dir_q.pop_front();
      checks++;
      if (d.act !== d.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", d.name, d.act, d.exp);
      end
    end
    if (bus.cond_valid === 1'b1 && stall_seen !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: cond_valid=1 cond_true=%b with no request outstanding",
                 bus.cond_true);
      end else begin
        r = exp_q.pop_front();
        if (bus.cond_true !== r.exp) begin
          errors++;
          $display("FAIL %s: cond_true=%b expected %b", r.name, bus.cond_true, r.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_dir(input string n, input logic [31:0] a, input logic [31:0] e);
    direct_t d;
    d.name = n;
    d.act  = a;
    d.exp  = e;
    dir_q.push_back(d);
  endtask

  task automatic load(input logic [3:0] f);
    bus.flags_we = 1'b1;
    bus.flags_in = f;
    bus.eval_req = 1'b0;
    step();
    bus.flags_we = 1'b0;
    expect_dir("sr_load", 32'(bus.flags_out), 32'(f));
  endtask

  // Issue one accepted request (no stall, no flush) and record its expected result.
  task automatic request(input logic [3:0] c, input logic e, input string n);
    result_t r;
    r.name = n;
    r.exp  = e;
    exp_q.push_back(r);
    bus.cond     = c;
    bus.eval_req = 1'b1;
    step();
    bus.eval_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] sv;
    logic [3:0] cv;
    reset        = 1'b1;
    bus.flags_in = 4'h0;
    bus.flags_we = 1'b0;
    bus.cond     = 4'h0;
    bus.eval_req = 1'b0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    step();
    step();
    expect_dir("reset_flags_out", 32'(bus.flags_out), 32'h0);
    expect_dir("reset_cond_valid", 32'(bus.cond_valid), 32'h0);
    expect_dir("reset_cond_true", 32'(bus.cond_true), 32'h0);
    reset = 1'b0;
    step();

    // Asynchronous reset mid-cycle with SR=1111 and a valid result showing.
    load(4'hF);
    request(4'hE, 1'b1, "pre_reset_al");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    expect_dir("async_reset_flags_out", 32'(bus.flags_out), 32'h0);
    expect_dir("async_reset_cond_valid", 32'(bus.cond_valid), 32'h0);
    expect_dir("async_reset_cond_true", 32'(bus.cond_true), 32'h0);
    step();
    reset = 1'b0;
    step();

    // Full table sweep: every SR value against every condition, back-to-back requests.
    for (int v = 0; v < 16; v++) begin
      sv = 4'(v);
      load(sv);
      for (int c = 0; c < 16; c++) begin
        cv = 4'(c);
        request(cv, truth[cv][sv], $sformatf("table_sr%0h_cond%0h", sv, cv));
      end
    end

    // Bypass: new flags (Z=0) written in the same cycle as an EQ request.
    load(4'b0100);
    bus.flags_we = 1'b1;
    bus.flags_in = 4'b0000;
    request(4'h0, 1'b0, "bypass_eq");
    bus.flags_we = 1'b0;
    expect_dir("bypass_sr_loaded", 32'(bus.flags_out), 32'h0);
    request(4'h0, 1'b0, "post_bypass_eq");
    request(4'h1, 1'b1, "post_bypass_ne");

    // Stall: result and SR held for three cycles despite flag writes and requests.
    request(4'hE, 1'b1, "pre_stall_al");
    bus.stall    = 1'b1;
    bus.flags_we = 1'b1;
    bus.flags_in = 4'hF;
    bus.eval_req = 1'b1;
    bus.cond     = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_dir("stall_cond_valid", 32'(bus.cond_valid), 32'h1);
      expect_dir("stall_cond_true", 32'(bus.cond_true), 32'h1);
      expect_dir("stall_flags_out", 32'(bus.flags_out), 32'h0);
    end
    bus.stall    = 1'b0;
    bus.flags_we = 1'b0;
    bus.eval_req = 1'b0;
    step();
    expect_dir("post_stall_cond_valid", 32'(bus.cond_valid), 32'h0);
    expect_dir("post_stall_cond_true", 32'(bus.cond_true), 32'h0);
    expect_dir("post_stall_flags_out", 32'(bus.flags_out), 32'h0);

    // Flush: drops the request but still loads SR, even with stall high.
    request(4'hE, 1'b1, "pre_flush_al");
    bus.flush    = 1'b1;
    bus.eval_req = 1'b1;
    bus.cond     = 4'hE;
    bus.flags_we = 1'b1;
    bus.flags_in = 4'hA;
    step();
    expect_dir("flush_cond_valid", 32'(bus.cond_valid), 32'h0);
    expect_dir("flush_cond_true", 32'(bus.cond_true), 32'h0);
    expect_dir("flush_flags_out", 32'(bus.flags_out), 32'hA);
    bus.stall    = 1'b1;
    bus.flags_in = 4'h5;
    step();
    expect_dir("flush_stall_flags_out", 32'(bus.flags_out), 32'h5);
    expect_dir("flush_stall_cond_valid", 32'(bus.cond_valid), 32'h0);
    bus.flush    = 1'b0;
    bus.stall    = 1'b0;
    bus.eval_req = 1'b0;
    bus.flags_we = 1'b0;
    step();

    // Signed compares.
    load(4'b1001);
    request(4'hC, 1'b1, "gt_n_eq_v");
    request(4'hB, 1'b0, "lt_n_eq_v");
    load(4'b1000);
    request(4'hC, 1'b0, "gt_n_ne_v");
    request(4'hD, 1'b1, "le_n_ne_v");

    step();
    step();
    expect_dir("leftover_results", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
